// File: rtl/mempool_link_arbiter.sv
// -----------------------------------------------------------------------------
// mempool_link_arbiter
//
// Shares one inter-group TCDM link direction between the tiles of a group.
// A round-robin arbiter picks one tile request per cycle into a registered
// output stage that drives the link. The granted tile index is recorded in an
// in-order ID FIFO, and each returning response is steered back to the tile
// at the FIFO head. The FIFO depth also caps the number of in-flight requests.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_i / req_valid_i     per-tile request payload and valid
//   req_ready_o             per-tile ready (only the granted tile, when the
//                           output stage is free and the ID FIFO is not full)
//   link_req_o              registered request towards the link
//   link_ini_o              tile index of link_req_o
//   link_req_valid_o        registered link request valid
//   link_req_ready_i        link request ready
//   link_resp_i / _valid_i  in-order response from the link
//   link_resp_ready_o       response ready (head tile ready, FIFO not empty)
//   resp_o                  response payload broadcast to every tile
//   resp_valid_o            per-tile response valid (head tile only)
//   resp_ready_i            per-tile response ready
//   outstanding_o           number of requests in flight (ID FIFO fill level)
// -----------------------------------------------------------------------------
module mempool_link_arbiter #(
    parameter int unsigned NumInp         = 4,
    parameter int unsigned ReqWidth       = 64,
    parameter int unsigned RespWidth      = 32,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumInp-1:0][ReqWidth-1:0]       req_i,
    input  logic [NumInp-1:0]                     req_valid_i,
    output logic [NumInp-1:0]                     req_ready_o,
    output logic [ReqWidth-1:0]                   link_req_o,
    output logic [$clog2(NumInp)-1:0]             link_ini_o,
    output logic                                  link_req_valid_o,
    input  logic                                  link_req_ready_i,
    input  logic [RespWidth-1:0]                  link_resp_i,
    input  logic                                  link_resp_valid_i,
    output logic                                  link_resp_ready_o,
    output logic [NumInp-1:0][RespWidth-1:0]      resp_o,
    output logic [NumInp-1:0]                     resp_valid_o,
    input  logic [NumInp-1:0]                     resp_ready_i,
    output logic [$clog2(MaxOutstanding):0]       outstanding_o
);

    localparam int unsigned IdxWidth = $clog2(NumInp);
    localparam int unsigned PtrWidth = $clog2(MaxOutstanding);
    localparam int unsigned CntWidth = PtrWidth + 1;

    // Arbitration
    logic [IdxWidth-1:0] rr_r;
    logic [IdxWidth-1:0] scan_idx_s;
    logic [IdxWidth-1:0] grant_idx_s;
    logic                grant_found_s;
    logic                out_free_s;
    logic                can_accept_s;
    logic [NumInp-1:0]   req_ready_s;
    logic                push_s;

    // Registered output stage
    logic [ReqWidth-1:0] link_req_r;
    logic [IdxWidth-1:0] link_ini_r;
    logic                link_req_valid_r;

    // ID FIFO
    logic [IdxWidth-1:0] id_mem_r [MaxOutstanding];
    logic [PtrWidth-1:0] wr_ptr_r;
    logic [PtrWidth-1:0] rd_ptr_r;
    logic [CntWidth-1:0] cnt_r;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [IdxWidth-1:0] head_idx_s;

    // Response steering
    logic [NumInp-1:0]   resp_valid_s;
    logic                link_resp_ready_s;
    logic                pop_s;

    // Rotating priority search starting at rr_r; index arithmetic wraps
    // naturally because NumInp is a power of two.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = rr_r;
        scan_idx_s    = rr_r;
        for (int unsigned i = 0; i < NumInp; i++) begin
            scan_idx_s    = rr_r + IdxWidth'(i);
            grant_idx_s   = (!grant_found_s && req_valid_i[scan_idx_s]) ? scan_idx_s : grant_idx_s;
            grant_found_s = grant_found_s | req_valid_i[scan_idx_s];
        end
    end

    // The output stage can take a new request when it is empty or being
    // drained this cycle. A pop in the same cycle as full does not count:
    // acceptance looks only at the registered fill level.
    assign out_free_s   = !link_req_valid_r || link_req_ready_i;
    assign fifo_full_s  = (cnt_r == CntWidth'(MaxOutstanding));
    assign fifo_empty_s = (cnt_r == {CntWidth{1'b0}});
    assign can_accept_s = grant_found_s && out_free_s && !fifo_full_s;

    // One-hot ready towards the granted tile only.
    always_comb begin
        req_ready_s              = {NumInp{1'b0}};
        req_ready_s[grant_idx_s] = can_accept_s;
    end

    assign push_s      = req_valid_i[grant_idx_s] && req_ready_s[grant_idx_s];
    assign req_ready_o = req_ready_s;

    // Round-robin pointer advances past the tile that was just accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_r <= {IdxWidth{1'b0}};
        end else if (push_s) begin
            rr_r <= grant_idx_s + IdxWidth'(1'b1);
        end
    end

    // Registered link request stage; the payload holds while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            link_req_r       <= {ReqWidth{1'b0}};
            link_ini_r       <= {IdxWidth{1'b0}};
            link_req_valid_r <= 1'b0;
        end else if (push_s) begin
            link_req_r       <= req_i[grant_idx_s];
            link_ini_r       <= grant_idx_s;
            link_req_valid_r <= 1'b1;
        end else if (link_req_valid_r && link_req_ready_i) begin
            link_req_valid_r <= 1'b0;
        end
    end

    assign link_req_o       = link_req_r;
    assign link_ini_o       = link_ini_r;
    assign link_req_valid_o = link_req_valid_r;

    // ID FIFO storage and pointers; pointers wrap modulo the depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                id_mem_r[i] <= {IdxWidth{1'b0}};
            end
            wr_ptr_r <= {PtrWidth{1'b0}};
            rd_ptr_r <= {PtrWidth{1'b0}};
        end else begin
            if (push_s) begin
                id_mem_r[wr_ptr_r] <= grant_idx_s;
                wr_ptr_r           <= wr_ptr_r + PtrWidth'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PtrWidth'(1'b1);
            end
        end
    end

    // In-flight counter; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= {CntWidth{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CntWidth'(1'b1);
                2'b01:   cnt_r <= cnt_r - CntWidth'(1'b1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign outstanding_o = cnt_r;
    assign head_idx_s    = id_mem_r[rd_ptr_r];

    // Steer the response to the tile at the FIFO head. With an empty FIFO
    // nothing is valid and the link is never acknowledged.
    always_comb begin
        resp_valid_s             = {NumInp{1'b0}};
        resp_valid_s[head_idx_s] = link_resp_valid_i && !fifo_empty_s;
        link_resp_ready_s        = resp_ready_i[head_idx_s] && !fifo_empty_s;
    end

    assign resp_valid_o      = resp_valid_s;
    assign link_resp_ready_o = link_resp_ready_s;
    assign pop_s             = link_resp_valid_i && link_resp_ready_s;
    assign resp_o            = {NumInp{link_resp_i}};

    mempool_link_arbiter_checker #(
        .NumInp         (NumInp),
        .ReqWidth       (ReqWidth),
        .MaxOutstanding (MaxOutstanding)
    ) i_checker (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req_ready         (req_ready_s),
        .link_req          (link_req_r),
        .link_ini          (link_ini_r),
        .link_req_valid    (link_req_valid_r),
        .link_req_ready    (link_req_ready_i),
        .link_resp_valid   (link_resp_valid_i),
        .fifo_empty        (fifo_empty_s),
        .outstanding       (cnt_r)
    );

endmodule

// -----------------------------------------------------------------------------
// mempool_link_arbiter_checker
//
// Protocol and invariant properties for mempool_link_arbiter.
//
// Ports:
//   clk_i, rst_ni       clock and reset of the observed block
//   req_ready           per-tile ready vector
//   link_req, link_ini  registered link payload and tile index
//   link_req_valid/ready  link request handshake
//   link_resp_valid     response valid from the link
//   fifo_empty          ID FIFO empty flag
//   outstanding         in-flight count
// -----------------------------------------------------------------------------
module mempool_link_arbiter_checker #(
    parameter int unsigned NumInp         = 4,
    parameter int unsigned ReqWidth       = 64,
    parameter int unsigned MaxOutstanding = 8
) (
    input logic                              clk_i,
    input logic                              rst_ni,
    input logic [NumInp-1:0]                 req_ready,
    input logic [ReqWidth-1:0]               link_req,
    input logic [$clog2(NumInp)-1:0]         link_ini,
    input logic                              link_req_valid,
    input logic                              link_req_ready,
    input logic                              link_resp_valid,
    input logic                              fifo_empty,
    input logic [$clog2(MaxOutstanding):0]   outstanding
);

    // A response with no recorded requester cannot be routed.
    resp_without_request: assert property (
        @(posedge clk_i) disable iff (!rst_ni) link_resp_valid |-> !fifo_empty);

    // At most one tile sees ready in any cycle.
    ready_onehot: assert property (
        @(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready));

    // The in-flight count never exceeds the ID FIFO depth.
    count_bound: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        outstanding <= ($clog2(MaxOutstanding) + 1)'(MaxOutstanding));

    // A stalled link request keeps its payload and index.
    payload_stable: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (link_req_valid && !link_req_ready) |=>
            (link_req_valid && $stable(link_req) && $stable(link_ini)));

endmodule

// File: tb/tb_mempool_link_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for mempool_link_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-based reference model of the
// arbitration, in-order ID tracking and response steering rules.
// -----------------------------------------------------------------------------
module tb_mempool_link_arbiter;

    localparam int NUM = 4;
    localparam int RW  = 64;
    localparam int SW  = 32;
    localparam int MO  = 8;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic [NUM-1:0][RW-1:0] req_i;
    logic [NUM-1:0]         req_valid_i;
    logic [NUM-1:0]         req_ready_o;
    logic [RW-1:0]          link_req_o;
    logic [1:0]             link_ini_o;
    logic                   link_req_valid_o;
    logic                   link_req_ready_i;
    logic [SW-1:0]          link_resp_i;
    logic                   link_resp_valid_i;
    logic                   link_resp_ready_o;
    logic [NUM-1:0][SW-1:0] resp_o;
    logic [NUM-1:0]         resp_valid_o;
    logic [NUM-1:0]         resp_ready_i;
    logic [3:0]             outstanding_o;

    mempool_link_arbiter #(
        .NumInp(NUM), .ReqWidth(RW), .RespWidth(SW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .link_req_o(link_req_o), .link_ini_o(link_ini_o),
        .link_req_valid_o(link_req_valid_o), .link_req_ready_i(link_req_ready_i),
        .link_resp_i(link_resp_i), .link_resp_valid_i(link_resp_valid_i),
        .link_resp_ready_o(link_resp_ready_o),
        .resp_o(resp_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    int    n_cmp  = 0;
    int    n_fail = 0;
    string phase  = "init";

    // Reference model state
    int          m_rr;
    int          m_q[$];
    logic [RW-1:0] m_link_req;
    logic [1:0]  m_ini;
    bit          m_lvalid;

    // Model outputs for the current inputs
    logic [3:0]  e_req_ready;
    logic [3:0]  e_resp_valid;
    logic        e_lresp_ready;
    int          e_g;
    bit          e_found;

    logic [RW-1:0] pay0, pay1;
    logic [3:0]    onehot;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr       = 0;
        m_q.delete();
        m_link_req = '0;
        m_ini      = 2'd0;
        m_lvalid   = 1'b0;
    endtask

    task automatic model_comb();
        bit free, full;
        e_found = 1'b0;
        e_g     = 0;
        for (int k = 0; k < NUM; k++) begin
            int idx;
            idx = (m_rr + k) % NUM;
            if (!e_found && req_valid_i[idx]) begin
                e_found = 1'b1;
                e_g     = idx;
            end
        end
        free        = !m_lvalid || link_req_ready_i;
        full        = (m_q.size() == MO);
        e_req_ready = (e_found && free && !full) ? 4'(1 << e_g) : 4'b0000;
        if (m_q.size() > 0) begin
            e_resp_valid  = link_resp_valid_i ? 4'(1 << m_q[0]) : 4'b0000;
            e_lresp_ready = resp_ready_i[m_q[0]];
        end else begin
            e_resp_valid  = 4'b0000;
            e_lresp_ready = 1'b0;
        end
    endtask

    task automatic check_all();
        model_comb();
        chk("req_ready",       128'(req_ready_o),       128'(e_req_ready));
        chk("resp_valid",      128'(resp_valid_o),      128'(e_resp_valid));
        chk("link_resp_ready", 128'(link_resp_ready_o), 128'(e_lresp_ready));
        chk("resp_o",          128'(resp_o),            128'({NUM{link_resp_i}}));
        chk("link_req_valid",  128'(link_req_valid_o),  128'(m_lvalid));
        chk("link_req",        128'(link_req_o),        128'(m_link_req));
        chk("link_ini",        128'(link_ini_o),        128'(m_ini));
        chk("outstanding",     128'(outstanding_o),     128'(m_q.size()));
    endtask

    task automatic model_step();
        bit accept, pop;
        model_comb();
        accept = (e_req_ready != 4'b0000);
        pop    = link_resp_valid_i && e_lresp_ready;
        if (pop) void'(m_q.pop_front());
        if (accept) begin
            m_q.push_back(e_g);
            m_link_req = req_i[e_g];
            m_ini      = e_g[1:0];
            m_lvalid   = 1'b1;
            m_rr       = (e_g + 1) % NUM;
        end else if (m_lvalid && link_req_ready_i) begin
            m_lvalid = 1'b0;
        end
    endtask

    // One checked clock cycle: entered and left at posedge + 1.
    task automatic cyc();
        #1;
        check_all();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_i             = '0;
        req_valid_i       = 4'b0000;
        link_req_ready_i  = 1'b0;
        link_resp_i       = '0;
        link_resp_valid_i = 1'b0;
        resp_ready_i      = 4'b0000;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk_i);
        #1;
        check_all();
        rst_ni = 1'b1;
    endtask

    task automatic drain();
        req_valid_i      = 4'b0000;
        link_req_ready_i = 1'b1;
        resp_ready_i     = 4'b1111;
        for (int c = 0; c < 30 && (m_q.size() > 0 || m_lvalid); c++) begin
            link_resp_i       = $urandom;
            link_resp_valid_i = (m_q.size() > 0);
            cyc();
        end
        link_resp_valid_i = 1'b0;
        #1;
        chk("drained_outstanding", 128'(outstanding_o), 128'd0);
        chk("drained_valid",       128'(link_req_valid_o), 128'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b1;
        idle_inputs();
        model_reset();
        #2;

        // Reset values
        phase = "reset";
        apply_reset();
        chk("rst_link_req_valid", 128'(link_req_valid_o), 128'd0);
        chk("rst_outstanding",    128'(outstanding_o),    128'd0);

        // Single request from tile 2
        phase = "single";
        req_i[2]    = 64'h0000_0000_0000_00A5;
        req_valid_i = 4'b0100;
        #1;
        chk("single_ready", 128'(req_ready_o), 128'(4'b0100));
        cyc();
        req_valid_i = 4'b0000;
        chk("single_lvalid", 128'(link_req_valid_o), 128'd1);
        chk("single_ini",    128'(link_ini_o),       128'd2);
        chk("single_req",    128'(link_req_o),       128'h0A5);
        chk("single_out",    128'(outstanding_o),    128'd1);
        link_req_ready_i = 1'b1;
        cyc();
        link_resp_i       = 32'h0000_0011;
        link_resp_valid_i = 1'b1;
        resp_ready_i      = 4'b1111;
        #1;
        chk("single_resp_valid", 128'(resp_valid_o), 128'(4'b0100));
        chk("single_resp_data",  128'(resp_o[2]),    128'h11);
        cyc();
        link_resp_valid_i = 1'b0;
        chk("single_out_after", 128'(outstanding_o), 128'd0);

        // Fairness: grants 0,1,2,3,0,... with responses keeping the count low
        phase = "fair";
        apply_reset();
        req_valid_i      = 4'b1111;
        link_req_ready_i = 1'b1;
        resp_ready_i     = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            for (int l = 0; l < NUM; l++) req_i[l] = {$urandom, $urandom};
            link_resp_i       = $urandom;
            link_resp_valid_i = (m_q.size() > 0);
            onehot            = 4'b0001 << (k % NUM);
            #1;
            chk("fair_grant", 128'(req_ready_o), 128'(onehot));
            cyc();
        end
        drain();

        // Backpressure: tile 0 registered, link stalls 5 cycles, then tile 1
        phase = "backpressure";
        apply_reset();
        pay0 = {$urandom, $urandom};
        pay1 = {$urandom, $urandom};
        req_i[0]    = pay0;
        req_i[1]    = pay1;
        req_valid_i = 4'b0011;
        cyc();
        req_valid_i = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready_blocked", 128'(req_ready_o), 128'd0);
            chk("bp_payload_hold",  128'(link_req_o),  128'(pay0));
            cyc();
        end
        link_req_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", 128'(req_ready_o), 128'(4'b0010));
        cyc();
        chk("bp_next_ini", 128'(link_ini_o), 128'd1);
        chk("bp_next_req", 128'(link_req_o), 128'(pay1));
        drain();

        // Full: eight accepts with responses withheld
        phase = "full";
        apply_reset();
        req_valid_i      = 4'b1111;
        link_req_ready_i = 1'b1;
        for (int k = 0; k < MO; k++) begin
            for (int l = 0; l < NUM; l++) req_i[l] = {$urandom, $urandom};
            cyc();
        end
        #1;
        chk("full_out",   128'(outstanding_o), 128'd8);
        chk("full_ready", 128'(req_ready_o),   128'd0);
        link_resp_i       = $urandom;
        link_resp_valid_i = 1'b1;
        resp_ready_i      = 4'b1111;
        #1;
        chk("full_pop_same_cycle", 128'(req_ready_o), 128'd0);
        cyc();
        link_resp_valid_i = 1'b0;
        #1;
        chk("full_resume", 128'(req_ready_o), 128'(4'b0001));
        cyc();
        chk("full_out_refill", 128'(outstanding_o), 128'd8);
        drain();

        // Ordering: tiles 3,0,3 with tile 0 stalling its response
        phase = "order";
        apply_reset();
        link_req_ready_i = 1'b1;
        req_valid_i = 4'b1000; cyc();
        req_valid_i = 4'b0001; cyc();
        req_valid_i = 4'b1000; cyc();
        req_valid_i = 4'b0000;
        link_resp_valid_i = 1'b1;
        resp_ready_i      = 4'b1111;
        link_resp_i       = 32'hAAAA_0003;
        #1;
        chk("order_first", 128'(resp_valid_o), 128'(4'b1000));
        cyc();
        resp_ready_i = 4'b1110;
        link_resp_i  = 32'hAAAA_0000;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("order_stall_valid", 128'(resp_valid_o),      128'(4'b0001));
            chk("order_stall_ready", 128'(link_resp_ready_o), 128'd0);
            cyc();
        end
        resp_ready_i = 4'b1111;
        cyc();
        chk("order_out_before", 128'(outstanding_o), 128'd1);
        req_valid_i = 4'b0100;
        link_resp_i = 32'hAAAA_0013;
        #1;
        chk("order_last", 128'(resp_valid_o), 128'(4'b1000));
        cyc();
        chk("order_push_pop", 128'(outstanding_o), 128'd1);
        drain();

        // Reset mid-flight with four outstanding
        phase = "midreset";
        apply_reset();
        req_valid_i      = 4'b1111;
        link_req_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < NUM; l++) req_i[l] = {$urandom, $urandom};
            cyc();
        end
        chk("mid_out4", 128'(outstanding_o), 128'd4);
        apply_reset();
        chk("mid_out0",   128'(outstanding_o),    128'd0);
        chk("mid_lvalid", 128'(link_req_valid_o), 128'd0);
        req_i[1]    = 64'h1234_5678_9ABC_DEF0;
        req_valid_i = 4'b0010;
        cyc();
        req_valid_i = 4'b0000;
        chk("mid_after_ini", 128'(link_ini_o), 128'd1);
        drain();

        // Random traffic against the model
        phase = "random";
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid_i = 4'($urandom);
            for (int l = 0; l < NUM; l++) req_i[l] = {$urandom, $urandom};
            link_req_ready_i  = ($urandom_range(0, 3) != 0);
            link_resp_i       = $urandom;
            link_resp_valid_i = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
            resp_ready_i      = 4'($urandom) | 4'($urandom);
            cyc();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
